// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential MIPS DIV/DIVU unit.
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BUSY   = 2'b01,
    DIV_BYZERO = 2'b10,
    DIV_DONE   = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quot
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // rem < divisor always holds, so the shifted partial remainder and the
  // trial difference both fit in WIDTH+1 bits; the MSB is the borrow.
  always_comb begin
    shifted_s = {rem, quot[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, divisor};
    if (diff_s[WIDTH] == 1'b0) begin
      next_rem  = diff_s[WIDTH-1:0];
      next_quot = {quot[WIDTH-2:0], 1'b1};
    end else begin
      next_rem  = shifted_s[WIDTH-1:0];
      next_quot = {quot[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider for MIPS DIV/DIVU with its own sequencing FSM.
// Result is {remainder, quotient}, valid while ready is high.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  input  logic               stall_i,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] STEPS = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  div_state_e       state_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] divisor_r;
  logic [CNT_W-1:0] count_r;
  logic             neg_quot_r;
  logic             neg_rem_r;

  logic [WIDTH-1:0] dividend_abs_s;
  logic [WIDTH-1:0] divisor_abs_s;
  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quot_s;
  logic [WIDTH-1:0] fix_quot_s;
  logic [WIDTH-1:0] fix_rem_s;

  // Operand magnitudes at accept, and sign fix-up of the finished magnitudes.
  always_comb begin
    if (signed_div && opdata1[WIDTH-1]) begin
      dividend_abs_s = -opdata1;
    end else begin
      dividend_abs_s = opdata1;
    end
    if (signed_div && opdata2[WIDTH-1]) begin
      divisor_abs_s = -opdata2;
    end else begin
      divisor_abs_s = opdata2;
    end
    if (neg_quot_r) begin
      fix_quot_s = -quot_r;
    end else begin
      fix_quot_s = quot_r;
    end
    if (neg_rem_r) begin
      fix_rem_s = -rem_r;
    end else begin
      fix_rem_s = rem_r;
    end
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem_r),
    .quot      (quot_r),
    .divisor   (divisor_r),
    .next_rem  (step_rem_s),
    .next_quot (step_quot_s)
  );

  // Sequencing FSM; annul behaves like a soft reset one level below rst.
  always_ff @(posedge clk) begin
    if (rst || annul) begin
      state_r    <= DIV_IDLE;
      ready      <= 1'b0;
      result     <= {(2*WIDTH){1'b0}};
      count_r    <= {CNT_W{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      quot_r     <= {WIDTH{1'b0}};
      divisor_r  <= {WIDTH{1'b0}};
      neg_quot_r <= 1'b0;
      neg_rem_r  <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          ready <= 1'b0;
          if (start) begin
            rem_r      <= {WIDTH{1'b0}};
            quot_r     <= dividend_abs_s;
            divisor_r  <= divisor_abs_s;
            count_r    <= {CNT_W{1'b0}};
            neg_quot_r <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_rem_r  <= signed_div & opdata1[WIDTH-1];
            if (opdata2 == {WIDTH{1'b0}}) begin
              state_r <= DIV_BYZERO;
            end else begin
              state_r <= DIV_BUSY;
            end
          end else begin
            state_r <= DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          if (count_r < STEPS) begin
            rem_r   <= step_rem_s;
            quot_r  <= step_quot_s;
            count_r <= count_r + CNT_ONE;
          end else begin
            result  <= {fix_rem_s, fix_quot_s};
            ready   <= 1'b1;
            state_r <= DIV_DONE;
          end
        end
        DIV_BYZERO: begin
          result  <= {(2*WIDTH){1'b0}};
          ready   <= 1'b1;
          state_r <= DIV_DONE;
        end
        DIV_DONE: begin
          if (stall_i) begin
            ready   <= 1'b1;
            state_r <= DIV_DONE;
          end else begin
            ready   <= 1'b0;
            state_r <= DIV_IDLE;
          end
        end
        default: begin
          ready   <= 1'b0;
          state_r <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table plus multi-cycle corner sequences.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        stall_i;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[16];

  div_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .stall_i    (stall_i),
    .result     (result),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference quotient/remainder from the language's own division operators.
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sd) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  // Present operands for exactly one edge, then scramble them.
  task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    signed_div = sd;
    opdata1 = a;
    opdata2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    signed_div = ~sd;
    opdata1 = $urandom;
    opdata2 = $urandom;
  endtask

  // Count edges until ready is seen high (sampled 1 time unit after each edge).
  task automatic wait_ready(output int edges);
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (ready) break;
    end
  endtask

  task automatic expect_done(input string name, input int exp_edges, input logic [63:0] exp_res);
    int edges;
    logic [63:0] sb_exp;
    wait_ready(edges);
    check({name, "_latency"}, 64'(edges), 64'(exp_edges));
    if (ready && exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      check({name, "_result"}, result, sb_exp);
    end else begin
      check({name, "_ready_seen"}, {63'd0, ready}, 64'd1);
    end
    check({name, "_exp_tracked"}, sb_exp, exp_res);
  endtask

  task automatic watch_no_ready(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    check(name, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    int lat;
    logic [63:0] held;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; opdata1 = 32'd0; opdata2 = 32'd0;
    annul = 1'b0; stall_i = 1'b0;

    vecs[0]  = '{1'b0, 32'd7,          32'd2,          {32'h1, 32'h3}};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000}};
    vecs[3]  = '{1'b0, 32'd100,        32'd0,          64'd0};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0, 32'hFFFF_FFFF}};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'h0, 32'h1}};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h1, 32'hFFFF_FFFD}};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'h3}};
    vecs[8]  = '{1'b0, 32'd3,          32'd10,         {32'h3, 32'h0}};
    vecs[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0}};
    vecs[10] = '{1'b1, 32'd0,          32'd5,          64'd0};
    vecs[11] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          64'd0};
    for (int i = 12; i < 16; i++) begin
      vecs[i].sd = 1'(i % 2);
      vecs[i].a  = $urandom;
      vecs[i].b  = $urandom >> $urandom_range(0, 31);
      if (vecs[i].b == 32'd0) vecs[i].b = 32'd3;
      vecs[i].exp = model(vecs[i].sd, vecs[i].a, vecs[i].b);
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(vecs[i].exp);
      issue(vecs[i].sd, vecs[i].a, vecs[i].b);
      expect_done($sformatf("vec%0d", i), (vecs[i].b == 32'd0) ? 1 : 33, vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_release_ready", i), {63'd0, ready}, 64'd0);
      check($sformatf("vec%0d_release_hold", i), result, vecs[i].exp);
    end

    // Annul during BUSY, then a fresh divide the very next cycle.
    issue(1'b0, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    check("annul_ready", {63'd0, ready}, 64'd0);
    check("annul_result", result, 64'd0);
    exp_q.push_back({32'd6, 32'd142});
    issue(1'b0, 32'd1000, 32'd7);
    expect_done("after_annul", 33, {32'd6, 32'd142});
    @(posedge clk);
    #1;

    // Annul wins over a simultaneous start.
    start = 1'b1; annul = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0; annul = 1'b0;
    watch_no_ready("annul_over_start", 40);

    // Hold in DONE under stall, then a back-to-back request held across release.
    stall_i = 1'b1;
    exp_q.push_back({32'hFFFF_FFFE, 32'hFFFF_FFFA});
    issue(1'b1, 32'hFFFF_FFE0, 32'd5);
    expect_done("stall_op", 33, {32'hFFFF_FFFE, 32'hFFFF_FFFA});
    held = result;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall_ready_c%0d", c), {63'd0, ready}, 64'd1);
      check($sformatf("stall_result_c%0d", c), result, {32'hFFFF_FFFE, 32'hFFFF_FFFA});
    end
    stall_i = 1'b0;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd81; opdata2 = 32'd9;
    @(posedge clk);
    #1;
    check("b2b_release_ready", {63'd0, ready}, 64'd0);
    check("b2b_release_hold", result, held);
    exp_q.push_back({32'd0, 32'd9});
    @(posedge clk);
    #1;
    start = 1'b0; opdata1 = $urandom; opdata2 = $urandom;
    expect_done("b2b", 33, {32'd0, 32'd9});
    @(posedge clk);
    #1;

    // Synchronous reset in the middle of BUSY.
    issue(1'b0, 32'd12345, 32'd3);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy_ready", {63'd0, ready}, 64'd0);
    check("rst_busy_result", result, 64'd0);
    watch_no_ready("rst_no_stale_ready", 40);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
